if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 18 +
 rtl/if_id_buffer_fetch_fifo.sv | 64 ++++++
 rtl/if_id_buffer.sv | 89 ++++++++
 tb/tb_if_id_buffer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared fetch/decode pipeline types.
// Holds the buffer FSM states, the halt word and the fetch packet.
package if_id_buffer_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } buf_state_e;

  localparam logic [31:0] HALT_INST_C = 32'h0000000C;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_buffer_fetch_fifo.sv
// Circular fetch-packet store between fetch and decode.
// The owner never pushes when full; clear beats push and pop.
import if_id_buffer_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fetch_pkt_t             wdata_i,
  output fetch_pkt_t             rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  fetch_pkt_t    mem_q [DEPTH];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  // Empty buffer presents a NOP.
  assign rdata_o = (cnt_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID skid buffer with halt draining and redirect flush.
// Storage lives in fetch_fifo; halt/flush control lives here.
import if_id_buffer_pkg::*;

module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] HALT_INST = HALT_INST_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc4,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc4,
  output logic        halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  buf_state_e    state_q, state_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] count;
  fetch_pkt_t    wpkt, rpkt;
  logic          push, pop, clr;

  assign wpkt      = '{inst: in_inst, pc4: in_pc4};
  assign in_ready  = (count < CW'(DEPTH)) &&
                     (state_q == RUN) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_inst  = rpkt.inst;
  assign out_pc4   = rpkt.pc4;
  assign halted    = halted_q;

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    clr      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush) clr = 1'b1;
        else if (push && in_inst == HALT_INST)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (flush) begin
          clr     = 1'b1;
          state_d = RUN;
        end else if (pop && rpkt.inst == HALT_INST) begin
          clr      = 1'b1;
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr),
    .push_i (push),
    .pop_i  (pop && !clr),
    .wdata_i(wpkt),
    .rdata_o(rpkt),
    .count_o(count)
  );

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed plus random checking of if_id_buffer against a queue model.
// Inputs change on the falling edge; outputs are checked just after.
module tb_if_id_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] HALT  = 32'h0000000C;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush;
  logic        out_valid, out_ready, halted;
  logic [31:0] in_inst, in_pc4, out_inst, out_pc4;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } pkt_t;

  pkt_t q[$];
  int   mst = 0;
  bit   mhalt = 1'b0;
  bit   known = 1'b0;

  always #5 clk = ~clk;

  if_id_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc4   (in_pc4),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_pc4  (out_pc4),
    .halted   (halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mst: 0 = running, 1 = draining toward halt, 2 = halted
  task automatic cyc(input bit rst, input bit iv,
                     input logic [31:0] inst,
                     input logic [31:0] pc4,
                     input bit fl, input bit ordy);
    bit   e_rdy, e_vld, pu, po;
    pkt_t h;
    @(negedge clk);
    reset = rst; in_valid = iv; in_inst = inst;
    in_pc4 = pc4; flush = fl; out_ready = ordy;
    #1;
    e_rdy = (q.size() < DEPTH) && (mst == 0) && !fl;
    e_vld = (q.size() != 0);
    if (known) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_vld});
      chk("out_inst", out_inst, e_vld ? q[0].inst : 32'h0);
      chk("out_pc4", out_pc4, e_vld ? q[0].pc4 : 32'h0);
      chk("halted", {31'b0, halted}, {31'b0, mhalt});
    end
    @(posedge clk);
    pu = iv && e_rdy;
    po = e_vld && ordy;
    if (rst) begin
      q.delete(); mst = 0; mhalt = 1'b0; known = 1'b1;
    end else if (mst == 2) begin
    end else if (fl) begin
      q.delete(); mst = 0;
    end else begin
      if (po) begin
        h = q.pop_front();
        if (mst == 1 && h.inst == HALT) begin
          q.delete(); mst = 2; mhalt = 1'b1;
        end
      end
      if (pu) begin
        q.push_back('{inst: inst, pc4: pc4});
        if (inst == HALT) mst = 1;
      end
    end
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ordy);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = '0;
    in_pc4 = '0; flush = 1'b0; out_ready = 1'b0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h1, 32'h8, 1, 1);
    idle(0);
    // first packet visible one cycle after push
    cyc(0, 1, 32'h20080005, 32'd4, 0, 0);
    #1 chk("req31_inst", out_inst, 32'h20080005);
    chk("req31_pc4", out_pc4, 32'd4);
    idle(1);
    idle(0);

    cyc(0, 1, 32'hA1, 32'h10, 0, 0);
    cyc(0, 1, 32'hA2, 32'h14, 0, 0);
    cyc(0, 1, 32'hA3, 32'h18, 0, 0);
    idle(1); idle(1); idle(1);

    cyc(0, 1, 32'hB1, 32'h20, 0, 0);
    cyc(0, 1, 32'hB2, 32'h24, 0, 0);
    cyc(0, 1, 32'hB3, 32'h28, 0, 1);
    idle(0);
    idle(1); idle(1);

    cyc(0, 1, 32'hC1, 32'h30, 0, 0);
    cyc(0, 1, 32'hC2, 32'h34, 0, 0);
    cyc(0, 1, 32'hC3, 32'h38, 1, 1);
    idle(0);
    #1 chk("req34_valid", {31'b0, out_valid}, 32'h0);

    cyc(0, 1, HALT, 32'h40, 0, 0);
    cyc(0, 1, 32'h20090001, 32'h44, 0, 0);
    idle(1);
    idle(0);
    #1 chk("req35_halt", {31'b0, halted}, 32'h1);
    cyc(0, 1, 32'h5, 32'h48, 1, 1);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0);
    idle(0);

    cyc(0, 1, HALT, 32'h50, 0, 0);
    idle(0);
    cyc(0, 0, 0, 0, 1, 1);
    idle(0);
    #1 chk("req36_rdy", {31'b0, in_ready}, 32'h1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 149) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) == 0) ? HALT : $urandom,
          $urandom,
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
